// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode encodings, flag bit positions, update masks
// and the condition-code encodings consumed by CCodeEval.
package cpu_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned OPC_W  = 4;
  localparam int unsigned FLAG_W = 3;
  localparam int unsigned CC_W   = 3;

  typedef logic [FLAG_W-1:0] nvz_t;

  // Flag bit positions within {N,V,Z}
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_V = 1;
  localparam int unsigned FLAG_Z = 0;

  // Opcodes
  localparam logic [OPC_W-1:0] OP_ADD    = 4'b0000;
  localparam logic [OPC_W-1:0] OP_SUB    = 4'b0001;
  localparam logic [OPC_W-1:0] OP_XOR    = 4'b0010;
  localparam logic [OPC_W-1:0] OP_RED    = 4'b0011;
  localparam logic [OPC_W-1:0] OP_SLL    = 4'b0100;
  localparam logic [OPC_W-1:0] OP_SRA    = 4'b0101;
  localparam logic [OPC_W-1:0] OP_ROR    = 4'b0110;
  localparam logic [OPC_W-1:0] OP_PADDSB = 4'b0111;
  localparam logic [OPC_W-1:0] OP_LW     = 4'b1000;
  localparam logic [OPC_W-1:0] OP_SW     = 4'b1001;
  localparam logic [OPC_W-1:0] OP_LLB    = 4'b1010;
  localparam logic [OPC_W-1:0] OP_LHB    = 4'b1011;
  localparam logic [OPC_W-1:0] OP_B      = 4'b1100;
  localparam logic [OPC_W-1:0] OP_BR     = 4'b1101;
  localparam logic [OPC_W-1:0] OP_PCS    = 4'b1110;
  localparam logic [OPC_W-1:0] OP_HLT    = 4'b1111;

  // Flag update masks {mN,mV,mZ}
  localparam nvz_t MASK_ALL  = 3'b111;
  localparam nvz_t MASK_Z    = 3'b001;
  localparam nvz_t MASK_NONE = 3'b000;

  // Condition-code encodings evaluated by CCodeEval
  localparam logic [CC_W-1:0] CC_NEQ  = 3'b000;
  localparam logic [CC_W-1:0] CC_EQ   = 3'b001;
  localparam logic [CC_W-1:0] CC_GT   = 3'b010;
  localparam logic [CC_W-1:0] CC_LT   = 3'b011;
  localparam logic [CC_W-1:0] CC_GTE  = 3'b100;
  localparam logic [CC_W-1:0] CC_LTE  = 3'b101;
  localparam logic [CC_W-1:0] CC_OVFL = 3'b110;
  localparam logic [CC_W-1:0] CC_UNC  = 3'b111;

endpackage

// File: rtl/flag_unit_if.sv
// EX-stage to flag register bundle.
//   master: drives EX instruction info and pipeline controls, reads flags.
//   slave : the flag unit; consumes controls, drives nvz/nvz_fwd/shadow_nvz.
interface flag_unit_if;
  import cpu_pkg::*;

  logic              ex_valid;
  logic [OPC_W-1:0]  ex_opcode;
  logic [DATA_W-1:0] alu_out;
  logic              alu_ovfl;
  logic              stall;
  logic              flush;
  logic              save;
  logic              restore;
  nvz_t              nvz;
  nvz_t              nvz_fwd;
  nvz_t              shadow_nvz;

  modport master (
    output ex_valid, ex_opcode, alu_out, alu_ovfl, stall, flush, save, restore,
    input  nvz, nvz_fwd, shadow_nvz
  );

  modport slave (
    input  ex_valid, ex_opcode, alu_out, alu_ovfl, stall, flush, save, restore,
    output nvz, nvz_fwd, shadow_nvz
  );

endinterface

// File: rtl/flag_mask_dec.sv
// Opcode to {mN,mV,mZ} flag update mask, purely combinational.
//   opcode_i : instruction opcode
//   mask_o   : flags written by that opcode
module flag_mask_dec
  import cpu_pkg::*;
(
  input  logic [OPC_W-1:0] opcode_i,
  output nvz_t             mask_o
);

  always_comb begin
    mask_o = MASK_NONE;
    unique case (opcode_i)
      OP_ADD, OP_SUB:                 mask_o = MASK_ALL;
      OP_XOR, OP_SLL, OP_SRA, OP_ROR: mask_o = MASK_Z;
      default:                        mask_o = MASK_NONE;
    endcase
  end

endmodule

// File: rtl/flag_unit.sv
// Condition-code register stage: captures N/V/Z from the EX ALU result under
// a per-opcode mask, holds across stalls, ignores flushed instructions, and
// keeps a one-entry shadow for save/restore around traps.
//   clk, rst_n : clock, async active-low reset
//   bus        : flag_unit_if.slave (EX info, controls, nvz/nvz_fwd/shadow_nvz)
module flag_unit
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  flag_unit_if.slave  bus
);

  nvz_t nvz_q, nvz_d;
  nvz_t shadow_q, shadow_d;
  nvz_t mask;
  nvz_t new_nvz;
  nvz_t upd_nvz;
  logic upd;

  flag_mask_dec u_mask_dec (
    .opcode_i (bus.ex_opcode),
    .mask_o   (mask)
  );

  // Candidate flag values from the EX result
  always_comb begin
    new_nvz         = '0;
    new_nvz[FLAG_N] = bus.alu_out[DATA_W-1];
    new_nvz[FLAG_V] = bus.alu_ovfl;
    new_nvz[FLAG_Z] = (bus.alu_out == '0);
  end

  assign upd = bus.ex_valid & ~bus.stall & ~bus.flush;

  // Per-bit select keeps an X result out of unmasked bits
  always_comb begin
    upd_nvz = nvz_q;
    for (int unsigned i = 0; i < FLAG_W; i++) begin
      upd_nvz[i] = (upd && mask[i]) ? new_nvz[i] : nvz_q[i];
    end
  end

  // Restore wins over any EX update; save captures the pre-edge flags
  always_comb begin
    nvz_d    = bus.restore ? shadow_q : upd_nvz;
    shadow_d = bus.save ? nvz_q : shadow_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nvz_q    <= '0;
      shadow_q <= '0;
    end else begin
      nvz_q    <= nvz_d;
      shadow_q <= shadow_d;
    end
  end

  assign bus.nvz        = nvz_q;
  assign bus.nvz_fwd    = nvz_d;
  assign bus.shadow_nvz = shadow_q;

endmodule

// File: tb/tb_flag_unit.sv
// Directed, table-driven bench for flag_unit.
module tb_flag_unit;
  import cpu_pkg::*;

  logic clk;
  logic rst_n;

  flag_unit_if bus ();

  flag_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string             name;
    logic              valid;
    logic [OPC_W-1:0]  opc;
    logic [DATA_W-1:0] alu;
    logic              ovfl;
    logic              stall;
    logic              flush;
    logic              save;
    logic              restore;
    logic [2:0]        exp_fwd;
    logic [2:0]        exp_nvz;
    logic [2:0]        exp_sh;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", name, act, exp);
  endtask

  task automatic add_vec(input string name, input logic valid, input logic [OPC_W-1:0] opc,
                         input logic [DATA_W-1:0] alu, input logic ovfl, input logic stall,
                         input logic flush, input logic save, input logic restore,
                         input logic [2:0] e_fwd, input logic [2:0] e_nvz,
                         input logic [2:0] e_sh);
    vec_t v;
    v.name = name; v.valid = valid; v.opc = opc; v.alu = alu; v.ovfl = ovfl;
    v.stall = stall; v.flush = flush; v.save = save; v.restore = restore;
    v.exp_fwd = e_fwd; v.exp_nvz = e_nvz; v.exp_sh = e_sh;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    bus.ex_valid  = 1'b0;
    bus.ex_opcode = OP_HLT;
    bus.alu_out   = '0;
    bus.alu_ovfl  = 1'b0;
    bus.stall     = 1'b0;
    bus.flush     = 1'b0;
    bus.save      = 1'b0;
    bus.restore   = 1'b0;
  endtask

  initial begin
    drive_idle();
    rst_n = 1'b0;

    //       name        vld opcode     alu       ov st fl sv rs  fwd     nvz     shadow
    add_vec("add_8000",  1, OP_ADD,    16'h8000, 1, 0, 0, 0, 0, 3'b110, 3'b110, 3'b000);
    add_vec("xor_0",     1, OP_XOR,    16'h0000, 0, 0, 0, 0, 0, 3'b111, 3'b111, 3'b000);
    add_vec("xor_5",     1, OP_XOR,    16'h0005, 0, 0, 0, 0, 0, 3'b110, 3'b110, 3'b000);
    add_vec("sub_stl1",  1, OP_SUB,    16'h0000, 0, 1, 0, 0, 0, 3'b110, 3'b110, 3'b000);
    add_vec("sub_stl2",  1, OP_SUB,    16'h0000, 0, 1, 0, 0, 0, 3'b110, 3'b110, 3'b000);
    add_vec("sub_stl3",  1, OP_SUB,    16'h0000, 0, 1, 0, 0, 0, 3'b110, 3'b110, 3'b000);
    add_vec("sub_rel",   1, OP_SUB,    16'h0000, 0, 0, 0, 0, 0, 3'b001, 3'b001, 3'b000);
    add_vec("add_8000b", 1, OP_ADD,    16'h8000, 1, 0, 0, 0, 0, 3'b110, 3'b110, 3'b000);
    add_vec("sub_flush", 1, OP_SUB,    16'h0000, 0, 0, 1, 0, 0, 3'b110, 3'b110, 3'b000);
    add_vec("sub_stfl",  1, OP_SUB,    16'h0000, 0, 1, 1, 0, 0, 3'b110, 3'b110, 3'b000);
    add_vec("sub_inval", 0, OP_SUB,    16'h0000, 0, 0, 0, 0, 0, 3'b110, 3'b110, 3'b000);
    add_vec("lw",        1, OP_LW,     16'h0000, 1, 0, 0, 0, 0, 3'b110, 3'b110, 3'b000);
    add_vec("b",         1, OP_B,      16'h0000, 1, 0, 0, 0, 0, 3'b110, 3'b110, 3'b000);
    add_vec("paddsb",    1, OP_PADDSB, 16'h0000, 1, 0, 0, 0, 0, 3'b110, 3'b110, 3'b000);
    add_vec("red",       1, OP_RED,    16'h0000, 1, 0, 0, 0, 0, 3'b110, 3'b110, 3'b000);
    add_vec("add_n",     1, OP_ADD,    16'h8000, 0, 0, 0, 0, 0, 3'b100, 3'b100, 3'b000);
    add_vec("xor_z",     1, OP_XOR,    16'h0000, 0, 0, 0, 0, 0, 3'b101, 3'b101, 3'b000);
    add_vec("save",      0, OP_HLT,    16'h0000, 0, 0, 0, 1, 0, 3'b101, 3'b101, 3'b101);
    add_vec("add_1",     1, OP_ADD,    16'h0001, 0, 0, 0, 0, 0, 3'b000, 3'b000, 3'b101);
    add_vec("rst+add0",  1, OP_ADD,    16'h0000, 0, 0, 0, 0, 1, 3'b101, 3'b101, 3'b101);
    add_vec("add_ffff",  1, OP_ADD,    16'hFFFF, 1, 0, 0, 0, 0, 3'b110, 3'b110, 3'b101);
    add_vec("save2",     0, OP_HLT,    16'h0000, 0, 0, 0, 1, 0, 3'b110, 3'b110, 3'b110);
    add_vec("add_0",     1, OP_ADD,    16'h0000, 0, 0, 0, 0, 0, 3'b001, 3'b001, 3'b110);
    add_vec("swap",      0, OP_HLT,    16'h0000, 0, 0, 0, 1, 1, 3'b110, 3'b110, 3'b001);
    add_vec("save+upd",  1, OP_ADD,    16'h0001, 0, 0, 0, 1, 0, 3'b000, 3'b000, 3'b110);
    add_vec("add_ffff2", 1, OP_ADD,    16'hFFFF, 1, 0, 0, 0, 0, 3'b110, 3'b110, 3'b110);
    add_vec("sll_0",     1, OP_SLL,    16'h0000, 0, 0, 0, 0, 0, 3'b111, 3'b111, 3'b110);
    add_vec("sra_8000",  1, OP_SRA,    16'h8000, 0, 0, 0, 0, 0, 3'b110, 3'b110, 3'b110);
    add_vec("ror_0",     1, OP_ROR,    16'h0000, 0, 0, 0, 0, 0, 3'b111, 3'b111, 3'b110);
    add_vec("sw",        1, OP_SW,     16'h0001, 0, 0, 0, 0, 0, 3'b111, 3'b111, 3'b110);
    add_vec("hlt",       1, OP_HLT,    16'h8001, 0, 0, 0, 0, 0, 3'b111, 3'b111, 3'b110);

    // Reset state
    #2;
    check("reset_nvz", bus.nvz, 3'b000);
    check("reset_shadow", bus.shadow_nvz, 3'b000);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_reset_nvz", bus.nvz, 3'b000);

    // Table: drive at negedge, check forward mid-cycle, registers after edge
    foreach (vecs[i]) begin
      @(negedge clk);
      bus.ex_valid  = vecs[i].valid;
      bus.ex_opcode = vecs[i].opc;
      bus.alu_out   = vecs[i].alu;
      bus.alu_ovfl  = vecs[i].ovfl;
      bus.stall     = vecs[i].stall;
      bus.flush     = vecs[i].flush;
      bus.save      = vecs[i].save;
      bus.restore   = vecs[i].restore;
      #1;
      check({vecs[i].name, "_fwd"}, bus.nvz_fwd, vecs[i].exp_fwd);
      @(posedge clk);
      #1;
      check({vecs[i].name, "_nvz"}, bus.nvz, vecs[i].exp_nvz);
      check({vecs[i].name, "_shadow"}, bus.shadow_nvz, vecs[i].exp_sh);
    end

    // Unknown ALU result under a zero mask must leave flags intact
    @(negedge clk);
    drive_idle();
    bus.ex_valid  = 1'b1;
    bus.ex_opcode = OP_LW;
    bus.alu_out   = {DATA_W{1'bx}};
    bus.alu_ovfl  = 1'bx;
    #1;
    check("x_zero_mask_fwd", bus.nvz_fwd, 3'b111);
    @(posedge clk);
    #1;
    check("x_zero_mask_nvz", bus.nvz, 3'b111);

    // Asynchronous reset in the middle of a low phase
    @(negedge clk);
    drive_idle();
    #2;
    check("pre_async_nvz", bus.nvz, 3'b111);
    rst_n = 1'b0;
    #1;
    check("async_rst_nvz", bus.nvz, 3'b000);
    check("async_rst_shadow", bus.shadow_nvz, 3'b000);
    #1;
    rst_n = 1'b1;

    // Update after reset release still works
    @(negedge clk);
    bus.ex_valid  = 1'b1;
    bus.ex_opcode = OP_ADD;
    bus.alu_out   = 16'h8000;
    bus.alu_ovfl  = 1'b1;
    @(posedge clk);
    #1;
    check("post_async_add", bus.nvz, 3'b110);
    @(negedge clk);
    drive_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
